// File: rtl/uart_xcvr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_xcvr_pkg : shared parity mode and serial FSM state encodings    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_xcvr_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : flop-based FIFO, extra-MSB pointers, head read from regs |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok, pop_ok;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign level    = wr_ptr_q - rd_ptr_q;
  assign pop_ok   = pop & (~empty | push);
  assign push_ok  = push & (~full | pop_ok);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Storage is reset so the head outputs read as zero out of reset.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_fifo_xcvr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_fifo_xcvr : full-duplex UART with TX/RX FIFOs, runtime divider  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_fifo_xcvr
  import uart_xcvr_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          resetb,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_parity,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overrun,
  input  logic                          ovr_clr,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          txd,
  input  logic                          rxd
);
  localparam int               BIT_W    = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic              par_en_cfg, par_odd_cfg;
  assign par_en_cfg  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
  assign par_odd_cfg = (cfg_parity == PAR_ODD);

  // ---------------- TX path ----------------
  logic              tx_push, tx_pop, tx_full, tx_empty, tx_bit_end;
  logic [DATA_W-1:0] tx_head;
  uart_state_t       tx_state_q, tx_state_d;
  logic [DIV_W-1:0]  tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_par_en_q, tx_par_en_d, tx_par_bit_q, tx_par_bit_d;
  logic              txd_q, txd_d;

  assign tx_push    = tx_valid & tx_ready;
  assign tx_ready   = ~tx_full;
  assign tx_bit_end = (tx_cnt_q == tx_div_q - DIV_ONE);
  assign txd        = txd_q;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .resetb(resetb), .push(tx_push), .push_data(tx_data), .pop(tx_pop),
    .pop_data(tx_head), .level(tx_level), .full(tx_full), .empty(tx_empty)
  );

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_cnt_d     = (tx_state_q == IDLE || tx_bit_end) ? '0 : tx_cnt_q + DIV_ONE;
    tx_bit_d     = tx_bit_q;
    tx_shift_d   = tx_shift_q;
    tx_div_d     = tx_div_q;
    tx_par_en_d  = tx_par_en_q;
    tx_par_bit_d = tx_par_bit_q;
    tx_pop       = 1'b0;
    case (tx_state_q)
      IDLE:   tx_pop = ~tx_empty;
      START:  if (tx_bit_end) tx_state_d = DATA;
      DATA: begin
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == LAST_BIT) begin
            tx_bit_d   = '0;
            tx_state_d = tx_par_en_q ? PARITY : STOP;
          end else begin
            tx_bit_d = tx_bit_q + BIT_ONE;
          end
        end
      end
      PARITY: if (tx_bit_end) tx_state_d = STOP;
      STOP: begin
        if (tx_bit_end) begin
          if (tx_empty) tx_state_d = IDLE;
          else          tx_pop     = 1'b1;
        end
      end
      default: tx_state_d = IDLE;
    endcase
    if (tx_pop) begin
      tx_state_d   = START;
      tx_cnt_d     = '0;
      tx_bit_d     = '0;
      tx_shift_d   = tx_head;
      tx_div_d     = cfg_div;
      tx_par_en_d  = par_en_cfg;
      tx_par_bit_d = (^tx_head) ^ par_odd_cfg;
    end
    // The line is driven from the registered state, one clock behind it.
    case (tx_state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = tx_shift_q[0];
      PARITY:  txd_d = tx_par_bit_q;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      tx_state_q   <= IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_div_q     <= '0;
      tx_par_en_q  <= 1'b0;
      tx_par_bit_q <= 1'b0;
      txd_q        <= 1'b1;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_div_q     <= tx_div_d;
      tx_par_en_q  <= tx_par_en_d;
      tx_par_bit_q <= tx_par_bit_d;
      txd_q        <= txd_d;
    end
  end

  // ---------------- RX path ----------------
  logic                rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  logic                rx_pop, rx_full, rx_empty, rx_sample;
  logic [DATA_W+1:0]   rx_head, rx_word_q, rx_word_d;
  uart_state_t         rx_state_q, rx_state_d;
  logic [DIV_W-1:0]    rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [BIT_W-1:0]    rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic                rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d;
  logic                rx_perr_q, rx_perr_d, rx_push_q, rx_push_d, ovr_q, ovr_d;

  assign rx_pop     = rx_ready & ~rx_empty;
  assign rx_valid   = ~rx_empty;
  assign rx_data    = rx_head[DATA_W-1:0];
  assign rx_perr    = rx_head[DATA_W];
  assign rx_ferr    = rx_head[DATA_W+1];
  assign rx_overrun = ovr_q;
  assign rx_sample  = (rx_state_q == START) ? (rx_cnt_q == (rx_div_q >> 1) - DIV_ONE)
                                            : (rx_cnt_q == rx_div_q - DIV_ONE);

  sync_fifo #(.WIDTH(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .resetb(resetb), .push(rx_push_q), .push_data(rx_word_q), .pop(rx_pop),
    .pop_data(rx_head), .level(rx_level), .full(rx_full), .empty(rx_empty)
  );

  always_comb begin
    rx_meta_d    = rxd;
    rx_sync_d    = rx_meta_q;
    rx_prev_d    = rx_sync_q;
    rx_state_d   = rx_state_q;
    rx_cnt_d     = (rx_state_q == IDLE || rx_sample) ? '0 : rx_cnt_q + DIV_ONE;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_div_d     = rx_div_q;
    rx_par_en_d  = rx_par_en_q;
    rx_par_odd_d = rx_par_odd_q;
    rx_perr_d    = rx_perr_q;
    rx_word_d    = rx_word_q;
    rx_push_d    = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d   = START;
          rx_bit_d     = '0;
          rx_perr_d    = 1'b0;
          rx_div_d     = cfg_div;
          rx_par_en_d  = par_en_cfg;
          rx_par_odd_d = par_odd_cfg;
        end
      end
      START:  if (rx_sample) rx_state_d = rx_sync_q ? IDLE : DATA;
      DATA: begin
        if (rx_sample) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_W-1:1]};
          if (rx_bit_q == LAST_BIT) begin
            rx_bit_d   = '0;
            rx_state_d = rx_par_en_q ? PARITY : STOP;
          end else begin
            rx_bit_d = rx_bit_q + BIT_ONE;
          end
        end
      end
      PARITY: begin
        if (rx_sample) begin
          rx_perr_d  = ((^rx_shift_q) ^ rx_sync_q) != rx_par_odd_q;
          rx_state_d = STOP;
        end
      end
      STOP: begin
        if (rx_sample) begin
          rx_push_d  = 1'b1;
          rx_word_d  = {~rx_sync_q, rx_perr_q, rx_shift_q};
          rx_state_d = IDLE;
        end
      end
      default: rx_state_d = IDLE;
    endcase
    // A fresh overrun takes priority over a simultaneous clear.
    ovr_d = (rx_push_q & rx_full & ~rx_pop) | (ovr_q & ~ovr_clr);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_div_q     <= '0;
      rx_par_en_q  <= 1'b0;
      rx_par_odd_q <= 1'b0;
      rx_perr_q    <= 1'b0;
      rx_word_q    <= '0;
      rx_push_q    <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_div_q     <= rx_div_d;
      rx_par_en_q  <= rx_par_en_d;
      rx_par_odd_q <= rx_par_odd_d;
      rx_perr_q    <= rx_perr_d;
      rx_word_q    <= rx_word_d;
      rx_push_q    <= rx_push_d;
      ovr_q        <= ovr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_xcvr.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_fifo_xcvr : scoreboard bench for uart_fifo_xcvr              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_fifo_xcvr;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DIVW  = 16;
  localparam int DIV   = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            resetb = 1'b0;
  logic [DIVW-1:0] cfg_div = DIVW'(DIV);
  logic [1:0]      cfg_parity = 2'd0;
  logic [DW-1:0]   tx_data = '0;
  logic            tx_valid = 1'b0;
  logic            tx_ready;
  logic [DW-1:0]   rx_data;
  logic            rx_perr, rx_ferr, rx_valid;
  logic            rx_ready = 1'b0;
  logic            rx_overrun;
  logic            ovr_clr = 1'b0;
  logic [LW-1:0]   tx_level, rx_level;
  logic            txd;
  logic            rxd;
  logic            loopback = 1'b0;
  logic            rxd_drv = 1'b1;

  logic [DW+1:0]   sb_q[$];
  int              n_checks = 0;
  int              n_pass = 0;

  assign rxd = loopback ? txd : rxd_drv;
  always #5 clk = ~clk;

  uart_fifo_xcvr #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .DIV_W(DIVW)) dut (
    .clk(clk), .resetb(resetb), .cfg_div(cfg_div), .cfg_parity(cfg_parity),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_overrun(rx_overrun), .ovr_clr(ovr_clr),
    .tx_level(tx_level), .rx_level(rx_level), .txd(txd), .rxd(rxd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive_bit(input logic b);
    rxd_drv = b;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [DW-1:0] d, input logic par_en,
                             input logic par_bit, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (par_en) drive_bit(par_bit);
    drive_bit(stop_bit);
    drive_bit(1'b1);
  endtask

  task automatic read_rx(input string tag);
    int            t = 0;
    logic [DW+1:0] exp;
    while (!rx_valid && t < 40 * DIV) begin
      @(negedge clk);
      t++;
    end
    if (!rx_valid) begin
      check({tag, "_timeout"}, 32'(0), 32'(1));
      return;
    end
    if (sb_q.size() == 0) begin
      check({tag, "_unexpected"}, 32'(1), 32'(0));
    end else begin
      exp = sb_q.pop_front();
      check(tag, 32'({rx_ferr, rx_perr, rx_data}), 32'(exp));
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic send_tx(input logic [DW-1:0] d);
    int t = 0;
    while (!tx_ready && t < 40 * DIV) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) begin
      check("tx_ready_timeout", 32'(0), 32'(1));
      return;
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] cap_d;
    logic          cap_s, cap_p, cap_st;
    int            lows;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'(1));
    check("rst_tx_ready", 32'(tx_ready), 32'(1));
    check("rst_rx_valid", 32'(rx_valid), 32'(0));
    check("rst_overrun", 32'(rx_overrun), 32'(0));
    check("rst_rx_word", 32'({rx_ferr, rx_perr, rx_data}), 32'(0));
    check("rst_tx_level", 32'(tx_level), 32'(0));
    check("rst_rx_level", 32'(rx_level), 32'(0));
    resetb = 1'b1;
    repeat (3) @(negedge clk);

    // TX latency and even parity bit on the line for 0x41
    cfg_parity = 2'd1;
    tx_data    = 8'h41;
    tx_valid   = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_level_after_write", 32'(tx_level), 32'(1));
    check("txd_edge_n", 32'(txd), 32'(1));
    @(negedge clk);
    check("txd_edge_n1", 32'(txd), 32'(1));
    @(negedge clk);
    check("txd_edge_n2", 32'(txd), 32'(0));
    repeat (DIV / 2) @(negedge clk);
    cap_s = txd;
    for (int i = 0; i < DW; i++) begin
      repeat (DIV) @(negedge clk);
      cap_d[i] = txd;
    end
    repeat (DIV) @(negedge clk);
    cap_p = txd;
    repeat (DIV) @(negedge clk);
    cap_st = txd;
    check("tx_start_bit", 32'(cap_s), 32'(0));
    check("tx_data_bits", 32'(cap_d), 32'h41);
    check("tx_even_parity", 32'(cap_p), 32'(0));
    check("tx_stop_bit", 32'(cap_st), 32'(1));
    repeat (2 * DIV) @(negedge clk);
    check("tx_idle_level", 32'(tx_level), 32'(0));

    // RX parity: wrong even parity, correct even parity, correct odd parity
    sb_q.push_back({2'b01, 8'h41});
    drive_frame(8'h41, 1'b1, 1'b1, 1'b1);
    read_rx("rx_even_bad");
    sb_q.push_back({2'b00, 8'h41});
    drive_frame(8'h41, 1'b1, 1'b0, 1'b1);
    read_rx("rx_even_good");
    cfg_parity = 2'd2;
    sb_q.push_back({2'b00, 8'h41});
    drive_frame(8'h41, 1'b1, 1'b1, 1'b1);
    read_rx("rx_odd_good");

    // Frame error
    cfg_parity = 2'd0;
    sb_q.push_back({2'b10, 8'h55});
    drive_frame(8'h55, 1'b0, 1'b0, 1'b0);
    read_rx("rx_ferr");

    // False start followed by a clean frame
    rxd_drv = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    check("false_start_valid", 32'(rx_valid), 32'(0));
    check("false_start_level", 32'(rx_level), 32'(0));
    sb_q.push_back({2'b00, 8'hA5});
    drive_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    read_rx("rx_after_false_start");

    // Overrun with the consumer stalled
    for (int i = 1; i <= 5; i++) begin
      if (sb_q.size() < DEPTH) sb_q.push_back({2'b00, 8'(i)});
      drive_frame(8'(i), 1'b0, 1'b0, 1'b1);
    end
    check("ovr_level", 32'(rx_level), 32'(DEPTH));
    check("ovr_flag", 32'(rx_overrun), 32'(1));
    for (int i = 0; i < DEPTH; i++) read_rx("ovr_read");
    check("ovr_sticky", 32'(rx_overrun), 32'(1));
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_cleared", 32'(rx_overrun), 32'(0));

    // Echo loopback: "0123456789" then LF
    loopback = 1'b1;
    fork
      begin
        for (int i = 0; i < 11; i++) begin
          logic [DW-1:0] ch;
          ch = (i < 10) ? 8'(8'h30 + i) : 8'h0A;
          sb_q.push_back({2'b00, ch});
          send_tx(ch);
        end
      end
      begin
        for (int i = 0; i < 11; i++) read_rx("echo");
      end
    join
    check("echo_overrun", 32'(rx_overrun), 32'(0));
    check("echo_sb_empty", 32'(sb_q.size()), 32'(0));
    loopback = 1'b0;
    repeat (2 * DIV) @(negedge clk);

    // Mid-frame reset with three entries still queued
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    repeat (4) @(negedge clk);
    tx_valid = 1'b0;
    check("midrst_queued", 32'(tx_level), 32'(3));
    repeat (3 * DIV) @(negedge clk);
    check("midrst_txd_data", 32'(txd), 32'(0));
    #1 resetb = 1'b0;
    #1;
    check("midrst_txd_async", 32'(txd), 32'(1));
    check("midrst_tx_level", 32'(tx_level), 32'(0));
    @(negedge clk);
    resetb = 1'b1;
    lows = 0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (!txd) lows++;
    end
    check("midrst_idle_high", 32'(lows), 32'(0));
    check("midrst_level_after", 32'(tx_level), 32'(0));
    check("midrst_rx_valid", 32'(rx_valid), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
